// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - byte-stream command frame parser (checksum stage enabled by UART_CMD_CHKSUM_EN)
module uart_cmd_parser #(
    parameter int         clock_freq     = 100_000_000,
    parameter int         timeout_cycles = 100_000,
    parameter logic [7:0] header         = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rec,
    output logic        rx_clr,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        cmd_err
);

    // A zero timeout would give a zero-width counter, so keep at least one bit.
    localparam int               GAP_W   = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(timeout_cycles);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DATA,
`ifdef UART_CMD_CHKSUM_EN
        S_CHK,
`endif
        S_OUT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         addr_sh;
    logic [7:0]         addr_sh_next;
    logic [31:0]        data_sh;
    logic [31:0]        data_sh_next;
    logic [1:0]         idx;
    logic [1:0]         idx_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic               valid_next;
    logic               err_next;
    logic               load_out;
    logic               accept;
    logic               in_frame;
    logic               timeout;
    logic               take;

    // clock_freq documents the clock the timeout is scaled against; it drives no logic.
    logic unused_cfg;
    assign unused_cfg = (clock_freq != 0);

    // A byte is accepted only when no clear is in flight, so a level flag that is
    // still high during the clear cycle is not read twice.
    assign accept   = rx_rec && !rx_clr;
`ifdef UART_CMD_CHKSUM_EN
    assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
`else
    assign in_frame = (state == S_ADDR) || (state == S_DATA);
`endif
    assign timeout  = in_frame && (gap_cnt == GAP_MAX);
    // A byte arriving in the timeout cycle is cleared upstream but not parsed.
    assign take     = accept && !timeout;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] chk_sum;
    // Running sum of address and payload bytes, modulo 256.
    always_comb begin
        chk_sum = addr_sh + data_sh[31:24] + data_sh[23:16] + data_sh[15:8] + data_sh[7:0];
    end
`endif

    // Next-state and strobe decode; timeout overrides whatever the byte would have done.
    always_comb begin
        state_next   = state;
        addr_sh_next = addr_sh;
        data_sh_next = data_sh;
        idx_next     = idx;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        load_out     = 1'b0;
        if (timeout) begin
            state_next = S_HUNT;
            err_next   = 1'b1;
        end else begin
            case (state)
                S_HUNT: begin
                    if (take && (rx_data == header)) begin
                        state_next = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (take) begin
                        addr_sh_next = rx_data;
                        idx_next     = 2'd0;
                        state_next   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        data_sh_next = {data_sh[23:0], rx_data};
                        idx_next     = idx + 2'd1;
                        if (idx == 2'd3) begin
`ifdef UART_CMD_CHKSUM_EN
                            state_next = S_CHK;
`else
                            state_next = S_OUT;
`endif
                        end
                    end
                end
`ifdef UART_CMD_CHKSUM_EN
                S_CHK: begin
                    if (take) begin
                        if (rx_data == chk_sum) begin
                            state_next = S_OUT;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_HUNT;
                        end
                    end
                end
`endif
                S_OUT: begin
                    valid_next = 1'b1;
                    load_out   = 1'b1;
                    // A byte landing here is handled as if already back in HUNT.
                    if (take && (rx_data == header)) begin
                        state_next = S_ADDR;
                    end else begin
                        state_next = S_HUNT;
                    end
                end
                default: begin
                    state_next = S_HUNT;
                end
            endcase
        end
    end

    // Parser state, shadows and frame index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_HUNT;
            addr_sh <= 8'h00;
            data_sh <= 32'h0;
            idx     <= 2'd0;
        end else begin
            state   <= state_next;
            addr_sh <= addr_sh_next;
            data_sh <= data_sh_next;
            idx     <= idx_next;
        end
    end

    // Inter-byte gap counter: restarts on every accept, saturates, idle outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (accept || !in_frame) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // One-cycle clear back to the receiver for every accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_clr <= 1'b0;
        end else begin
            rx_clr <= accept;
        end
    end

    // Command outputs: registered strobes, data held until the next good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_addr  <= 8'h00;
            cmd_data  <= 32'h0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_valid <= valid_next;
            cmd_err   <= err_next;
            if (load_out) begin
                cmd_addr <= addr_sh;
                cmd_data <= data_sh;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rec = 1'b0;
    logic        rx_clr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_err;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int clr_cnt = 0;
    int both_cnt = 0;

`ifdef UART_CMD_CHKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    uart_cmd_parser #(
        .clock_freq     (100_000_000),
        .timeout_cycles (TO),
        .header         (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_rec    (rx_rec),
        .rx_clr    (rx_clr),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Strobe and clear tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_valid) valid_cnt++;
        if (cmd_err) err_cnt++;
        if (rx_clr) clr_cnt++;
        if (cmd_valid && cmd_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receiver model: flag held until the clear is seen, dropped one cycle later.
    task automatic send_byte(input logic [7:0] b);
        logic seen;
        int   n;
        seen    = 1'b0;
        n       = 0;
        rx_data = b;
        rx_rec  = 1'b1;
        while (!seen && n < 16) begin
            @(negedge clk);
            seen = rx_clr;
            @(posedge clk);
            #1;
            n++;
        end
        rx_rec = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $error("FAIL rx_clr_wait: observed none expected pulse for byte %0h", b);
        end
    endtask

    function automatic logic [7:0] csum(input logic [7:0] a, input logic [31:0] d);
        return a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

    // Returns in the cycle the command strobe is due for a good frame.
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] ck);
        send_byte(8'hA5);
        idle(1);
        send_byte(a);
        idle(1);
        for (int i = 3; i >= 0; i--) begin
            send_byte(d[8*i +: 8]);
`ifdef UART_CMD_CHKSUM_EN
            idle(1);
`else
            if (i != 0) idle(1);
`endif
        end
`ifdef UART_CMD_CHKSUM_EN
        send_byte(ck);
`else
        rx_data = ck;
`endif
    endtask

    task automatic expect_cmd(input logic [7:0] a, input logic [31:0] d);
        check("valid_latency", cmd_valid, 1'b1);
        check("no_err_with_valid", cmd_err, 1'b0);
        check("cmd_addr", cmd_addr, a);
        check("cmd_data", cmd_data, d);
    endtask

    initial begin
        int v0;
        int e0;
        int c0;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_clr", rx_clr, 1'b0);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        check("rst_addr", cmd_addr, 8'h00);
        check("rst_data", cmd_data, 32'h0);
        rst = 1'b0;
        idle(2);

        // Good frame
        v0 = valid_cnt; e0 = err_cnt; c0 = clr_cnt;
        send_frame(8'h10, 32'h12345678, csum(8'h10, 32'h12345678));
        expect_cmd(8'h10, 32'h12345678);
        idle(3);
        check("f1_valid_once", valid_cnt - v0, 1);
        check("f1_no_err", err_cnt - e0, 0);
        check("f1_one_clr_per_byte", clr_cnt - c0, FRAME_LEN);

`ifdef UART_CMD_CHKSUM_EN
        // Bad checksum: discarded, outputs keep the previous frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h33, 32'hCAFEF00D, 8'h00);
        idle(3);
        check("bad_chk_err_once", err_cnt - e0, 1);
        check("bad_chk_no_valid", valid_cnt - v0, 0);
        check("bad_chk_addr_held", cmd_addr, 8'h10);
        check("bad_chk_data_held", cmd_data, 32'h12345678);
`endif

        // Leading junk dropped silently
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h00);
        idle(1);
        send_byte(8'hFF);
        idle(1);
        send_frame(8'h01, 32'h00000002, csum(8'h01, 32'h00000002));
        expect_cmd(8'h01, 32'h00000002);
`ifndef UART_CMD_CHKSUM_EN
        send_byte(8'h03);
`endif
        idle(3);
        check("junk_valid_once", valid_cnt - v0, 1);
        check("junk_no_err", err_cnt - e0, 0);

        // Header value inside the payload is plain data
        send_frame(8'h20, 32'hA5000001, csum(8'h20, 32'hA5000001));
        expect_cmd(8'h20, 32'hA5000001);
        idle(3);

        // Inter-byte stall
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        idle(1);
        send_byte(8'h10);
        idle(1);
        send_byte(8'h12);
        n = 0;
        while (err_cnt == e0 && n < 3 * TO) begin
            idle(1);
            n++;
        end
        idle(3);
        check("stall_err_once", err_cnt - e0, 1);
        check("stall_no_valid", valid_cnt - v0, 0);
        check("stall_addr_held", cmd_addr, 8'h20);
        send_frame(8'h44, 32'h01020304, csum(8'h44, 32'h01020304));
        expect_cmd(8'h44, 32'h01020304);
        idle(3);

        // Byte arriving exactly at the timeout is cleared but dropped
        v0 = valid_cnt; e0 = err_cnt; c0 = clr_cnt;
        send_byte(8'hA5);
        idle(TO - 1);
        send_byte(8'h10);
        idle(3);
        check("edge_to_err_once", err_cnt - e0, 1);
        check("edge_to_byte_cleared", clr_cnt - c0, 2);
        send_byte(8'h12); idle(1);
        send_byte(8'h34); idle(1);
        send_byte(8'h56); idle(1);
        send_byte(8'h78); idle(1);
        send_byte(8'h24); idle(3);
        check("edge_to_no_valid", valid_cnt - v0, 0);
        check("edge_to_no_more_err", err_cnt - e0, 1);

        // Reset mid-frame
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        idle(1);
        send_byte(8'h10);
        idle(1);
        send_byte(8'h12);
        rst = 1'b1;
        idle(3);
        check("midrst_addr", cmd_addr, 8'h00);
        check("midrst_data", cmd_data, 32'h0);
        check("midrst_rx_clr", rx_clr, 1'b0);
        check("midrst_no_strobes", (valid_cnt - v0) + (err_cnt - e0), 0);
        rst = 1'b0;
        idle(2);
        send_frame(8'h5A, 32'hDEADBEEF, csum(8'h5A, 32'hDEADBEEF));
        expect_cmd(8'h5A, 32'hDEADBEEF);
        idle(3);
        check("midrst_valid_once", valid_cnt - v0, 1);
        check("midrst_no_err", err_cnt - e0, 0);

        check("valid_err_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
